// File: rtl/av_arbiter_2x1.sv
// Two-master to one-slave Avalon-MM arbiter. Round-robin grant, held for a
// whole transaction (write burst or read burst including its data beats), so
// read data needs no ID tracking to find its way back.
module av_arbiter_2x1 #(
  parameter int unsigned dw     = 32,
  parameter int unsigned aw     = 32,
  parameter int unsigned burstw = 8
) (
  input  logic              av_clk_i,
  input  logic              av_rst_n_i,
  // master 0
  input  logic [aw-1:0]     m0_address_i,
  input  logic [dw-1:0]     m0_writedata_i,
  input  logic [dw/8-1:0]   m0_byteenable_i,
  input  logic [burstw-1:0] m0_burstcount_i,
  input  logic              m0_write_i,
  input  logic              m0_read_i,
  output logic              m0_waitrequest_o,
  output logic              m0_readdatavalid_o,
  output logic [1:0]        m0_response_o,
  output logic [dw-1:0]     m0_readdata_o,
  // master 1
  input  logic [aw-1:0]     m1_address_i,
  input  logic [dw-1:0]     m1_writedata_i,
  input  logic [dw/8-1:0]   m1_byteenable_i,
  input  logic [burstw-1:0] m1_burstcount_i,
  input  logic              m1_write_i,
  input  logic              m1_read_i,
  output logic              m1_waitrequest_o,
  output logic              m1_readdatavalid_o,
  output logic [1:0]        m1_response_o,
  output logic [dw-1:0]     m1_readdata_o,
  // slave
  output logic [aw-1:0]     s_address_o,
  output logic [dw-1:0]     s_writedata_o,
  output logic [dw/8-1:0]   s_byteenable_o,
  output logic [burstw-1:0] s_burstcount_o,
  output logic              s_write_o,
  output logic              s_read_o,
  input  logic              s_waitrequest_i,
  input  logic              s_readdatavalid_i,
  input  logic [1:0]        s_response_i,
  input  logic [dw-1:0]     s_readdata_i,
  output logic [1:0]        grant_o
);

  localparam logic [burstw-1:0] CntOne = burstw'(1);

  typedef enum logic [1:0] {StIdle, StWrite, StReadCmd, StReadData} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;   // 1: m1 held the most recent grant
  logic [burstw-1:0] cnt_q, cnt_d;     // beats still owed in this transaction
  logic [burstw-1:0] cnt_rc;

  logic              req0, req1, win1, win_write;
  logic [burstw-1:0] win_bc;
  logic              sel, g_write, g_read;
  logic              rsp_err, m_wait, m_rdv;
  logic [1:0]        m_rsp;
  logic [dw-1:0]     m_rd;

  assign req0      = m0_write_i | m0_read_i;
  assign req1      = m1_write_i | m1_read_i;
  // m1 wins if it is alone, or if both request and m0 was served last
  assign win1      = req1 & (~req0 | ~last_q);
  assign win_write = win1 ? m1_write_i : m0_write_i;
  assign win_bc    = win1 ? m1_burstcount_i : m0_burstcount_i;

  assign sel     = grant_q[1];
  assign g_write = sel ? m1_write_i : m0_write_i;
  assign g_read  = sel ? m1_read_i : m0_read_i;

  // Slave signalled an error without data while a command is outstanding
  assign rsp_err = ((state_q == StWrite) || (state_q == StReadCmd)) & ~s_waitrequest_i &
                   (s_response_i != 2'b00) & ~s_readdatavalid_i;

  assign m_wait = (state_q == StReadData) | s_waitrequest_i;
  assign m_rdv  = ((state_q == StReadCmd) || (state_q == StReadData)) & s_readdatavalid_i;
  assign m_rsp  = (m_rdv | rsp_err) ? s_response_i : 2'b00;
  assign m_rd   = m_rdv ? s_readdata_i : '0;

  assign grant_o = grant_q;

  // Route the granted master to the slave and responses back to it
  always_comb begin
    s_address_o        = '0;
    s_writedata_o      = '0;
    s_byteenable_o     = '0;
    s_burstcount_o     = '0;
    s_write_o          = 1'b0;
    s_read_o           = 1'b0;
    m0_waitrequest_o   = 1'b1;
    m0_readdatavalid_o = 1'b0;
    m0_response_o      = 2'b00;
    m0_readdata_o      = '0;
    m1_waitrequest_o   = 1'b1;
    m1_readdatavalid_o = 1'b0;
    m1_response_o      = 2'b00;
    m1_readdata_o      = '0;
    if (state_q != StIdle) begin
      s_address_o    = sel ? m1_address_i : m0_address_i;
      s_writedata_o  = sel ? m1_writedata_i : m0_writedata_i;
      s_byteenable_o = sel ? m1_byteenable_i : m0_byteenable_i;
      s_burstcount_o = sel ? m1_burstcount_i : m0_burstcount_i;
      s_write_o      = (state_q == StWrite) & g_write;
      s_read_o       = (state_q == StReadCmd) & g_read;
      if (sel) begin
        m1_waitrequest_o   = m_wait;
        m1_readdatavalid_o = m_rdv;
        m1_response_o      = m_rsp;
        m1_readdata_o      = m_rd;
      end else begin
        m0_waitrequest_o   = m_wait;
        m0_readdatavalid_o = m_rdv;
        m0_response_o      = m_rsp;
        m0_readdata_o      = m_rd;
      end
    end
  end

  // Arbitration, beat counting and transaction sequencing
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_rc  = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          grant_d = win1 ? 2'b10 : 2'b01;
          last_d  = win1;
          cnt_d   = (win_bc == '0) ? CntOne : win_bc;
          state_d = win_write ? StWrite : StReadCmd;
        end
      end
      StWrite: begin
        if (rsp_err) begin
          state_d = StIdle;
          grant_d = 2'b00;
        end else if (s_write_o & ~s_waitrequest_i) begin
          if (cnt_q != '0) cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StIdle;
            grant_d = 2'b00;
          end
        end
      end
      StReadCmd: begin
        if (rsp_err) begin
          state_d = StIdle;
          grant_d = 2'b00;
        end else begin
          // a data beat arriving with the command acceptance still counts
          if (s_readdatavalid_i && (cnt_q != '0)) cnt_rc = cnt_q - CntOne;
          cnt_d = cnt_rc;
          if (s_read_o & ~s_waitrequest_i) begin
            if (cnt_rc == '0) begin
              state_d = StIdle;
              grant_d = 2'b00;
            end else begin
              state_d = StReadData;
            end
          end
        end
      end
      StReadData: begin
        if (s_readdatavalid_i) begin
          if (cnt_q != '0) cnt_d = cnt_q - CntOne;
          if (cnt_q <= CntOne) begin
            state_d = StIdle;
            grant_d = 2'b00;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  // State registers; last_q resets to m1 so m0 wins the first contest
  always_ff @(posedge av_clk_i or negedge av_rst_n_i) begin
    if (!av_rst_n_i) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_av_arbiter_2x1.sv
// Bench for av_arbiter_2x1: a vector table, directed multi-cycle sequences
// and random traffic checked against a transaction-level model.
module tb_av_arbiter_2x1;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 8;
  localparam int PW = 0, PRC = 1, PRD = 2;

  logic          av_clk_i = 1'b0;
  logic          av_rst_n_i = 1'b0;
  logic [AW-1:0] m0_address_i, m1_address_i, s_address_o;
  logic [DW-1:0] m0_writedata_i, m1_writedata_i, s_writedata_o;
  logic [DW/8-1:0] m0_byteenable_i, m1_byteenable_i, s_byteenable_o;
  logic [BW-1:0] m0_burstcount_i, m1_burstcount_i, s_burstcount_o;
  logic          m0_write_i, m0_read_i, m1_write_i, m1_read_i;
  logic          m0_waitrequest_o, m0_readdatavalid_o, m1_waitrequest_o, m1_readdatavalid_o;
  logic [1:0]    m0_response_o, m1_response_o, s_response_i, grant_o;
  logic [DW-1:0] m0_readdata_o, m1_readdata_o, s_readdata_i;
  logic          s_write_o, s_read_o, s_waitrequest_i, s_readdatavalid_i;

  av_arbiter_2x1 #(.dw(DW), .aw(AW), .burstw(BW)) dut (
    .av_clk_i(av_clk_i), .av_rst_n_i(av_rst_n_i),
    .m0_address_i(m0_address_i), .m0_writedata_i(m0_writedata_i),
    .m0_byteenable_i(m0_byteenable_i), .m0_burstcount_i(m0_burstcount_i),
    .m0_write_i(m0_write_i), .m0_read_i(m0_read_i),
    .m0_waitrequest_o(m0_waitrequest_o), .m0_readdatavalid_o(m0_readdatavalid_o),
    .m0_response_o(m0_response_o), .m0_readdata_o(m0_readdata_o),
    .m1_address_i(m1_address_i), .m1_writedata_i(m1_writedata_i),
    .m1_byteenable_i(m1_byteenable_i), .m1_burstcount_i(m1_burstcount_i),
    .m1_write_i(m1_write_i), .m1_read_i(m1_read_i),
    .m1_waitrequest_o(m1_waitrequest_o), .m1_readdatavalid_o(m1_readdatavalid_o),
    .m1_response_o(m1_response_o), .m1_readdata_o(m1_readdata_o),
    .s_address_o(s_address_o), .s_writedata_o(s_writedata_o),
    .s_byteenable_o(s_byteenable_o), .s_burstcount_o(s_burstcount_o),
    .s_write_o(s_write_o), .s_read_o(s_read_o),
    .s_waitrequest_i(s_waitrequest_i), .s_readdatavalid_i(s_readdatavalid_i),
    .s_response_i(s_response_i), .s_readdata_i(s_readdata_i),
    .grant_o(grant_o)
  );

  always #5 av_clk_i = ~av_clk_i;

  typedef struct packed {
    logic [1:0] grant; logic sw; logic sr; logic w0; logic w1; logic v0; logic v1;
    logic [1:0] r0; logic [1:0] r1;
    logic [AW-1:0] s_addr; logic [DW-1:0] s_wd; logic [DW/8-1:0] s_be; logic [BW-1:0] s_bc;
    logic [DW-1:0] rd0; logic [DW-1:0] rd1;
  } obs_t;

  typedef struct packed {
    logic [3:0] req;     // m0_write m0_read m1_write m1_read
    logic [7:0] bc0;
    logic [7:0] bc1;
    logic [3:0] slv;     // waitrequest readdatavalid response[1:0]
    logic [7:0] exp_ctl; // grant[1:0] s_write s_read m0_wait m1_wait m0_rdv m1_rdv
    logic [3:0] exp_rsp; // m0_response m1_response
  } vec_t;

  int n_cmp = 0, n_err = 0;
  // transaction-level model: who owns the slave, which phase, beats left
  int own, ph, rem, last;
  int acc1;
  logic [DW-1:0] rq[$];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic obs_t actual();
    obs_t a;
    a.grant = grant_o; a.sw = s_write_o; a.sr = s_read_o;
    a.w0 = m0_waitrequest_o; a.w1 = m1_waitrequest_o;
    a.v0 = m0_readdatavalid_o; a.v1 = m1_readdatavalid_o;
    a.r0 = m0_response_o; a.r1 = m1_response_o;
    a.s_addr = s_address_o; a.s_wd = s_writedata_o; a.s_be = s_byteenable_o;
    a.s_bc = s_burstcount_o; a.rd0 = m0_readdata_o; a.rd1 = m1_readdata_o;
    return a;
  endfunction

  function automatic obs_t idle_obs();
    obs_t e;
    e = '0; e.w0 = 1'b1; e.w1 = 1'b1;
    return e;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    logic mw, mr, wq, v, err;
    logic [1:0] rsp;
    logic [DW-1:0] rd;
    e = idle_obs();
    if (own >= 0) begin
      mw = (own == 1) ? m1_write_i : m0_write_i;
      mr = (own == 1) ? m1_read_i : m0_read_i;
      e.grant = (own == 1) ? 2'b10 : 2'b01;
      e.s_addr = (own == 1) ? m1_address_i : m0_address_i;
      e.s_wd = (own == 1) ? m1_writedata_i : m0_writedata_i;
      e.s_be = (own == 1) ? m1_byteenable_i : m0_byteenable_i;
      e.s_bc = (own == 1) ? m1_burstcount_i : m0_burstcount_i;
      e.sw = (ph == PW) && mw;
      e.sr = (ph == PRC) && mr;
      wq = (ph == PRD) || s_waitrequest_i;
      v = (ph != PW) && s_readdatavalid_i;
      err = (ph != PRD) && !s_waitrequest_i && (s_response_i != 2'b00) && !s_readdatavalid_i;
      rsp = (v || err) ? s_response_i : 2'b00;
      rd = v ? s_readdata_i : '0;
      if (own == 1) begin e.w1 = wq; e.v1 = v; e.r1 = rsp; e.rd1 = rd; end
      else begin e.w0 = wq; e.v0 = v; e.r0 = rsp; e.rd0 = rd; end
    end
    return e;
  endfunction

  task automatic model_adv();
    logic mw, mr, err, r0, r1;
    int win, bc;
    r0 = m0_write_i | m0_read_i;
    r1 = m1_write_i | m1_read_i;
    if (own < 0) begin
      if (r0 || r1) begin
        win = (r1 && (!r0 || last == 0)) ? 1 : 0;
        own = win; last = win;
        bc = (win == 1) ? int'(m1_burstcount_i) : int'(m0_burstcount_i);
        rem = (bc == 0) ? 1 : bc;
        ph = ((win == 1) ? m1_write_i : m0_write_i) ? PW : PRC;
      end
    end else begin
      mw = (own == 1) ? m1_write_i : m0_write_i;
      mr = (own == 1) ? m1_read_i : m0_read_i;
      err = (ph != PRD) && !s_waitrequest_i && (s_response_i != 2'b00) && !s_readdatavalid_i;
      if (ph == PW) begin
        if (err) own = -1;
        else if (mw && !s_waitrequest_i) begin rem--; if (rem == 0) own = -1; end
      end else if (ph == PRC) begin
        if (err) own = -1;
        else begin
          if (s_readdatavalid_i && rem > 0) rem--;
          if (mr && !s_waitrequest_i) begin
            if (rem == 0) own = -1; else ph = PRD;
          end
        end
      end else if (s_readdatavalid_i) begin
        if (rem > 0) rem--;
        if (rem == 0) own = -1;
      end
    end
  endtask

  task automatic model_reset();
    own = -1; ph = PW; rem = 0; last = 1;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance
  task automatic step(input string name);
    #1;
    chk(name, 256'(actual()), 256'(model_out()));
    if (s_write_o && !s_waitrequest_i && grant_o == 2'b10) acc1++;
    if (m0_readdatavalid_o) rq.push_back(m0_readdata_o);
    model_adv();
    @(posedge av_clk_i); #1;
  endtask

  task automatic clear_inputs();
    m0_write_i = 0; m0_read_i = 0; m1_write_i = 0; m1_read_i = 0;
    m0_burstcount_i = 8'd1; m1_burstcount_i = 8'd1;
    m0_address_i = 32'h10; m0_writedata_i = 32'hA5A5A5A5; m0_byteenable_i = 4'hF;
    m1_address_i = 32'h20; m1_writedata_i = 32'h5A5A0001; m1_byteenable_i = 4'h3;
    s_waitrequest_i = 1; s_readdatavalid_i = 0; s_response_i = 2'b00;
    s_readdata_i = 32'hDEAD0001;
  endtask

  task automatic do_reset();
    clear_inputs();
    av_rst_n_i = 0;
    m0_write_i = 1; m1_read_i = 1; s_waitrequest_i = 0;
    @(posedge av_clk_i); #2;
    chk("reset_outputs", 256'(actual()), 256'(idle_obs()));
    clear_inputs();
    @(negedge av_clk_i); av_rst_n_i = 1;
    model_reset();
    @(posedge av_clk_i); #1;
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{4'b0101, 8'd1, 8'd1, 4'b1000, 8'b00_00_11_00, 4'b0000};
    vt[1]  = '{4'b0101, 8'd1, 8'd1, 4'b0000, 8'b01_01_01_00, 4'b0000};
    vt[2]  = '{4'b0001, 8'd1, 8'd1, 4'b0000, 8'b01_00_11_00, 4'b0000};
    vt[3]  = '{4'b0001, 8'd1, 8'd1, 4'b0100, 8'b01_00_11_10, 4'b0000};
    vt[4]  = '{4'b0101, 8'd1, 8'd1, 4'b1000, 8'b00_00_11_00, 4'b0000};
    vt[5]  = '{4'b0101, 8'd1, 8'd1, 4'b0000, 8'b10_01_10_00, 4'b0000};
    vt[6]  = '{4'b0100, 8'd1, 8'd1, 4'b0110, 8'b10_00_11_01, 4'b0010};
    vt[7]  = '{4'b1000, 8'd4, 8'd1, 4'b1000, 8'b00_00_11_00, 4'b0000};
    vt[8]  = '{4'b1000, 8'd4, 8'd1, 4'b0010, 8'b01_10_01_00, 4'b1000};
    vt[9]  = '{4'b0010, 8'd1, 8'd1, 4'b1000, 8'b00_00_11_00, 4'b0000};
    vt[10] = '{4'b0010, 8'd1, 8'd1, 4'b1000, 8'b10_10_11_00, 4'b0000};
    vt[11] = '{4'b0010, 8'd1, 8'd1, 4'b0000, 8'b10_10_10_00, 4'b0000};
    vt[12] = '{4'b0000, 8'd1, 8'd1, 4'b0000, 8'b00_00_11_00, 4'b0000};

    // Table: single reads, round-robin, error beat, write error, single write
    do_reset();
    for (int i = 0; i < 13; i++) begin
      {m0_write_i, m0_read_i, m1_write_i, m1_read_i} = vt[i].req;
      m0_burstcount_i = vt[i].bc0; m1_burstcount_i = vt[i].bc1;
      {s_waitrequest_i, s_readdatavalid_i, s_response_i} = vt[i].slv;
      #1;
      chk($sformatf("vec%0d", i),
          256'({grant_o, s_write_o, s_read_o, m0_waitrequest_o, m1_waitrequest_o,
                m0_readdatavalid_o, m1_readdatavalid_o, m0_response_o, m1_response_o}),
          256'({vt[i].exp_ctl, vt[i].exp_rsp}));
      @(posedge av_clk_i); #1;
    end

    // m1 burst of 4 with a 2-cycle write gap; m0 waits until it is done
    do_reset();
    acc1 = 0;
    m1_write_i = 1; m1_burstcount_i = 8'd4; s_waitrequest_i = 0;
    step("burst_req");
    m0_read_i = 1;
    for (int i = 0; i < 6; i++) begin
      m1_write_i = !(i == 2 || i == 3);
      step("burst_beat");
    end
    m1_write_i = 0;
    step("burst_idle");
    chk("burst_beats", 256'(acc1), 256'(4));
    chk("burst_then_m0", 256'(grant_o), 256'(2'b01));

    // m0 read burst of 3 with gaps between data beats
    do_reset();
    rq.delete();
    m0_read_i = 1; m0_burstcount_i = 8'd3; s_waitrequest_i = 0;
    step("rd_grant");
    step("rd_cmd");
    m0_read_i = 0;
    begin
      logic [6:0] pat;
      int nb;
      pat = 7'b1001010;
      nb = 0;
      for (int i = 6; i >= 0; i--) begin
        s_readdatavalid_i = pat[i];
        if (pat[i]) begin nb++; s_readdata_i = DW'(nb); end
        step("rd_data");
      end
    end
    s_readdatavalid_i = 0;
    chk("rd_beats", 256'({32'(rq.size()), (rq.size() > 2) ? {rq[0], rq[1], rq[2]} : 96'h0}),
        256'({32'd3, 32'd1, 32'd2, 32'd3}));
    chk("rd_idle", 256'(grant_o), 256'(2'b00));

    // Reset in the middle of a burst, then m0 must win first again
    do_reset();
    m0_write_i = 1; m0_burstcount_i = 8'd4; s_waitrequest_i = 0;
    step("mid_grant");
    step("mid_beat1");
    m1_read_i = 1;
    av_rst_n_i = 0;
    #1;
    chk("mid_reset", 256'(actual()), 256'(idle_obs()));
    @(negedge av_clk_i); av_rst_n_i = 1;
    model_reset();
    step("mid_release");
    chk("mid_m0_first", 256'(grant_o), 256'(2'b01));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic gr;
      m0_write_i = ($urandom_range(3) == 0); m0_read_i = ($urandom_range(3) == 0);
      m1_write_i = ($urandom_range(3) == 0); m1_read_i = ($urandom_range(3) == 0);
      m0_burstcount_i = 8'($urandom_range(3)); m1_burstcount_i = 8'($urandom_range(3));
      m0_address_i = $urandom; m1_address_i = $urandom;
      m0_writedata_i = $urandom; m1_writedata_i = $urandom;
      m0_byteenable_i = 4'($urandom); m1_byteenable_i = 4'($urandom);
      s_waitrequest_i = ($urandom_range(2) == 0);
      s_response_i = ($urandom_range(7) == 0) ? 2'b10 : 2'b00;
      s_readdata_i = $urandom;
      gr = (own == 1) ? m1_read_i : m0_read_i;
      s_readdatavalid_i = (own >= 0) && (ph == PRD || (ph == PRC && gr && !s_waitrequest_i)) &&
                          ($urandom_range(1) == 1);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/av_arbiter_2x1.md
Name: av_arbiter_2x1

Overview:
Two-master to one-slave Avalon-MM arbiter with round-robin grant and burst awareness. It sits between two requesters (for example a CPU data port and a DMA engine) and a single shared Avalon slave, such as the slave BFM or a memory controller. Grant is held for the whole transaction: a write burst until its last beat is accepted, a read until its last readdatavalid beat returns. Read responses are therefore always routed to the master that issued them, with no ID FIFO.

Parameters:
dw, 32, data width in bits
aw, 32, address width in bits
burstw, 8, burstcount width; a burstcount of 0 is treated as 1

Ports:
av_clk_i  in  1  clock, all logic on rising edge
av_rst_n_i  in  1  asynchronous active-low reset
m0_address_i / m1_address_i  in  aw  master address
m0_writedata_i / m1_writedata_i  in  dw  write data
m0_byteenable_i / m1_byteenable_i  in  dw/8  byte enables
m0_burstcount_i / m1_burstcount_i  in  burstw  burst length
m0_write_i / m1_write_i  in  1  write request
m0_read_i / m1_read_i  in  1  read request
m0_waitrequest_o / m1_waitrequest_o  out  1  stall to master
m0_readdatavalid_o / m1_readdatavalid_o  out  1  read beat valid
m0_response_o / m1_response_o  out  2  response (00 OKAY, 10 SLAVEERROR)
m0_readdata_o / m1_readdata_o  out  dw  read data
s_address_o, s_writedata_o, s_byteenable_o, s_burstcount_o  out  aw/dw/dw/8/burstw  to slave
s_write_o, s_read_o  out  1  to slave
s_waitrequest_i, s_readdatavalid_i  in  1  from slave
s_response_i  in  2  from slave
s_readdata_i  in  dw  from slave
grant_o  out  2  one-hot current grant; 00 when idle

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, last_grant=1 so m0 wins first, beat counter=0.
- Output values in reset and IDLE:
  - s_read_o=0, s_write_o=0; other s_* outputs=0.
  - m*_waitrequest_o=1, m*_readdatavalid_o=0, m*_response_o=00, m*_readdata_o=0, grant_o=00.
- States: IDLE, WRITE, READ_CMD, READ_DATA.
- IDLE arbitration:
  - A master requests when read|write=1.
  - One requester: it wins. Both requesting: the master that is not last_grant wins.
  - On the next edge: grant registered, last_grant updated, beat counter loaded with max(burstcount,1).
  - Next state is WRITE if the winner's write=1, else READ_CMD. Write takes precedence if both read and write are high.
  - Request-to-slave latency is 1 cycle.
- Non-IDLE routing:
  - Granted master's command signals drive s_* combinationally.
  - Granted m_waitrequest_o = s_waitrequest_i.
  - Non-granted master: waitrequest=1, readdatavalid=0, readdata=0, response=00.
- WRITE:
  - s_write_o follows the granted master's write, so a master deasserting write mid-burst stalls the burst while grant is held.
  - Each cycle with s_write_o & !s_waitrequest_i decrements the counter.
  - Acceptance at counter==1 -> IDLE.
- READ_CMD:
  - s_read_o forwarded.
  - s_read_o & !s_waitrequest_i -> READ_DATA.
  - A readdatavalid in the same cycle as acceptance is counted.
- READ_DATA:
  - s_read_o=0 and granted m_waitrequest_o=1 (no new command).
  - Each s_readdatavalid_i passes readdatavalid, readdata and response to the granted master and decrements the counter.
  - Beat at counter==1 -> IDLE.
- Error termination: in WRITE or READ_CMD, a cycle with s_waitrequest_i=0, s_response_i!=00 and s_readdatavalid_i=0 is forwarded to the granted master and returns to IDLE.
- A SLAVEERROR on a readdatavalid beat is forwarded and counted normally; the burst is not aborted.
- Counter width is burstw; it never wraps below 0.
- A new grant is issued earliest the cycle after return to IDLE, so one idle bubble separates transactions.
- A reset mid-transaction aborts immediately to reset values. The in-flight slave transaction is abandoned; the slave must also be reset.

Test Plan:
- m0 single write (addr 0x10, data 0xA5A5A5A5, be 0xF, bc=1) -> s_write_o high 1 cycle after request; m0_waitrequest_o low on the accept cycle; back to IDLE; m1_waitrequest_o stays 1.
- m0 and m1 both request a single read in the same cycle after reset -> m0 served first, then m1. Repeat with both requesting -> m1 served first (round-robin). m1 readdatavalid never asserts during m0's read.
- m1 write burst bc=4 with m1_write_i dropped for 2 cycles after beat 2 -> grant held; exactly 4 accepted beats; m0 request pending throughout is granted only afterwards.
- m0 read burst bc=3; slave returns beats 0x1,0x2,0x3 with gaps -> m0 sees 3 valid beats in order; s_read_o=0 in READ_DATA; IDLE after beat 3.
- Slave answers m0 write with waitrequest=0, response=10 -> m0_response_o=10 that cycle; state returns to IDLE; m1 then granted.
- Assert av_rst_n_i low mid-burst (beat 2 of 4) -> all outputs take reset values immediately; after release, m0 has first priority.
